// File: rtl/mux_4_to_1.sv
// rtl/mux_4_to_1.sv - Registered 4-to-1 multiplexer with combinational and validated outputs
//
// Purpose:
//   Leaf datapath-select element. Picks one of four WIDTH-bit inputs using the
//   2-bit select {s1,s0} and presents the result both combinationally and
//   through a load-enabled register with a one-cycle valid strobe.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   en         in   1      load enable for the registered output
//   s0, s1     in   1      select LSB / MSB
//   i0..i3     in   WIDTH  data inputs for {s1,s0} = 00, 01, 10, 11
//   out_comb   out  WIDTH  combinational mux result
//   out        out  WIDTH  registered mux result
//   out_valid  out  1      high for the cycle following each enabled load

module mux_4_to_1 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             s0,
   input  logic             s1,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   output logic [WIDTH-1:0] out_comb,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);

   logic [WIDTH-1:0] sel_lo;
   logic [WIDTH-1:0] sel_hi;
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;
   logic             valid_d;
   logic             valid_q;

   // Two-level ternary tree rather than a case statement: an X on a select
   // bit then merges the candidates bitwise, so X appears only on bits where
   // the candidate inputs actually differ, like the transmission-gate mux.
   assign sel_lo   = s0 ? i1 : i0;
   assign sel_hi   = s0 ? i3 : i2;
   assign out_comb = s1 ? sel_hi : sel_lo;

   always_comb begin
      out_d   = out_q;
      valid_d = 1'b0;
      if (en) begin
         out_d   = out_comb;
         valid_d = 1'b1;
      end
   end

   // Reset takes priority over a simultaneous load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_4_to_1.sv
// tb/tb_mux_4_to_1.sv - Self-checking bench for mux_4_to_1 (WIDTH=1 and WIDTH=8)

module tb_mux_4_to_1;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       en;
   logic       s0, s1;
   logic       i0, i1, i2, i3;
   logic       out_comb, out, out_valid;

   logic       en8;
   logic       s0_8, s1_8;
   logic [7:0] a0, a1, a2, a3;
   logic [7:0] out_comb8, out8;
   logic       out_valid8;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   mux_4_to_1 #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .s0(s0), .s1(s1),
      .i0(i0), .i1(i1), .i2(i2), .i3(i3),
      .out_comb(out_comb), .out(out), .out_valid(out_valid)
   );

   mux_4_to_1 #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en8), .s0(s0_8), .s1(s1_8),
      .i0(a0), .i1(a1), .i2(a2), .i3(a3),
      .out_comb(out_comb8), .out(out8), .out_valid(out_valid8)
   );

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic [5:0] k);
      {s1, s0, i3, i2, i1, i0} = k;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      en8   = 1'b1;
      drive1(6'b111000);
      {s1_8, s0_8} = 2'b11;
      a0 = 8'h11; a1 = 8'h22; a2 = 8'h33; a3 = 8'h44;
      edge_sample();
      checks++;
      if (out !== 1'b0) begin errors++; $display("FAIL reset_out got %b want 0", out); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++;
      if (out_comb !== 1'b1) begin errors++; $display("FAIL reset_comb got %b want 1", out_comb); end
      checks++;
      if (out8 !== 8'h00) begin errors++; $display("FAIL reset_out8 got %h want 00", out8); end
      checks++;
      if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid8 got %b want 0", out_valid8); end
      en8 = 1'b0;
   endtask

   task automatic test_sweep();
      logic [5:0] k;
      logic [3:0] data;
      logic [1:0] sel;
      logic       e;
      logic [7:0] popped;
      rst_n = 1'b1;
      en    = 1'b1;
      for (int n = 0; n < 64; n++) begin
         k    = n[5:0];
         data = k[3:0];
         sel  = k[5:4];
         e    = data[sel];
         drive1(k);
         #1;
         checks++;
         if (out_comb !== e) begin errors++; $display("FAIL sweep_comb k=%0d got %b want %b", n, out_comb, e); end
         exp_q.push_back({7'd0, e});
         edge_sample();
         popped = exp_q.pop_front();
         checks++;
         if (out !== popped[0] || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sweep_out k=%0d got %b/%b want %b/1", n, out, out_valid, popped[0]);
         end
         if (k == 6'b000001 || k == 6'b010010 || k == 6'b100100 || k == 6'b111000) begin
            checks++;
            if (out !== 1'b1) begin errors++; $display("FAIL spot k=%b got %b want 1", k, out); end
         end
         if (k == 6'b110111 || k == 6'b000000) begin
            checks++;
            if (out !== 1'b0) begin errors++; $display("FAIL spot k=%b got %b want 0", k, out); end
         end
      end
   endtask

   task automatic test_hold();
      rst_n = 1'b1;
      en    = 1'b1;
      drive1(6'b100100);
      edge_sample();
      checks++;
      if (out !== 1'b1 || out_valid !== 1'b1) begin
         errors++; $display("FAIL hold_load got %b/%b want 1/1", out, out_valid);
      end
      en = 1'b0;
      i2 = 1'b0;
      #1;
      checks++;
      if (out_comb !== 1'b0) begin errors++; $display("FAIL hold_comb got %b want 0", out_comb); end
      for (int c = 0; c < 3; c++) begin
         edge_sample();
         checks++;
         if (out !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_keep c=%0d got %b/%b want 1/0", c, out, out_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [5:0] stream [4];
      logic [7:0] popped;
      logic [3:0] data;
      stream[0] = 6'b000001;
      stream[1] = 6'b111000;
      stream[2] = 6'b010010;
      stream[3] = 6'b110111;
      rst_n = 1'b1;
      en    = 1'b1;
      for (int n = 0; n < 4; n++) begin
         drive1(stream[n]);
         data = stream[n][3:0];
         exp_q.push_back({7'd0, data[stream[n][5:4]]});
         rst_n = (n == 2) ? 1'b0 : 1'b1;
         edge_sample();
         popped = exp_q.pop_front();
         if (n == 2) begin
            checks++;
            if (out !== 1'b0 || out_valid !== 1'b0) begin
               errors++; $display("FAIL mid_reset got %b/%b want 0/0", out, out_valid);
            end
         end else begin
            checks++;
            if (out !== popped[0] || out_valid !== 1'b1) begin
               errors++; $display("FAIL mid_stream n=%0d got %b/%b want %b/1", n, out, out_valid, popped[0]);
            end
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_width8();
      logic [7:0] want [4];
      logic [7:0] popped;
      want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33; want[3] = 8'h44;
      rst_n = 1'b1;
      en8   = 1'b1;
      a0 = 8'h11; a1 = 8'h22; a2 = 8'h33; a3 = 8'h44;
      for (int s = 0; s < 4; s++) begin
         {s1_8, s0_8} = s[1:0];
         #1;
         checks++;
         if (out_comb8 !== want[s]) begin errors++; $display("FAIL w8_comb s=%0d got %h want %h", s, out_comb8, want[s]); end
         exp_q.push_back(want[s]);
         edge_sample();
         popped = exp_q.pop_front();
         checks++;
         if (out8 !== popped || out_valid8 !== 1'b1) begin
            errors++; $display("FAIL w8_out s=%0d got %h/%b want %h/1", s, out8, out_valid8, popped);
         end
      end
      en8 = 1'b0;
      a3  = 8'hA5;
      edge_sample();
      checks++;
      if (out8 !== 8'h44 || out_valid8 !== 1'b0 || out_comb8 !== 8'hA5) begin
         errors++; $display("FAIL w8_hold got %h/%b/%h want 44/0/a5", out8, out_valid8, out_comb8);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b0; en8 = 1'b0;
      s0 = 1'b0; s1 = 1'b0; i0 = 1'b0; i1 = 1'b0; i2 = 1'b0; i3 = 1'b0;
      s0_8 = 1'b0; s1_8 = 1'b0; a0 = '0; a1 = '0; a2 = '0; a3 = '0;
      #1;
      test_reset();
      test_sweep();
      test_hold();
      test_reset_mid();
      test_width8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
